// File: rtl/trace_window_controller.sv
// trace_window_controller
//
// Control-register front end and trace-window sequencer. Decodes the control
// address space, holds trigger/range/stop configuration, and runs the window
// FSM that selects which retired instructions reach the trace filter. Also
// keeps a free-running clock counter and the timestamp of the last forwarded
// trace item.
//
// Optional feature macro: CMS_TRACE_CTRL_WFI_STOP_EN
//   defined   : WFI detection and the STOPPED state are built in.
//   undefined : no STOPPED state, WFI is traced like any instruction,
//               WFI_STOPPED writes are ignored and reads return 0.
//
// Control address map (ctrl_addr_t):
//   0x00 START_EN    0x01 END_EN      0x02 START_ADDR   0x03 END_ADDR
//   0x04 LOWER_EN    0x05 UPPER_EN    0x06 LOWER        0x07 UPPER
//   0x08 WFI_STOPPED 0x09 CLK_COUNTER 0x0A LAST_WRITE_TIMESTAMP (read-only)
//   all other addresses: writes ignored, reads return 0.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   i_ctrl_addr          control register address
//   i_ctrl_wdata         control write data
//   i_ctrl_write_enable  write strobe, one write per high cycle
//   o_ctrl_rdata         registered read data for the previous cycle's address
//   i_pc/i_instr         retired instruction address / encoding
//   i_instr_valid        retired instruction valid
//   o_trace_valid        forwarded instruction valid (registered)
//   o_trace_pc/instr     forwarded instruction (held between items)
//   o_tracing_active     FSM in TRACING
//   o_wfi_stopped        FSM in STOPPED
module trace_window_controller #(
  parameter int unsigned XLEN              = 64,
  parameter int unsigned INSTR_WIDTH       = 32,
  parameter int unsigned CTRL_ADDR_WIDTH   = 8,
  parameter int unsigned CTRL_DATA_WIDTH   = 64,
  parameter int unsigned CLK_COUNTER_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CTRL_ADDR_WIDTH-1:0] i_ctrl_addr,
  input  logic [CTRL_DATA_WIDTH-1:0] i_ctrl_wdata,
  input  logic                       i_ctrl_write_enable,
  output logic [CTRL_DATA_WIDTH-1:0] o_ctrl_rdata,
  input  logic [XLEN-1:0]            i_pc,
  input  logic [INSTR_WIDTH-1:0]     i_instr,
  input  logic                       i_instr_valid,
  output logic                       o_trace_valid,
  output logic [XLEN-1:0]            o_trace_pc,
  output logic [INSTR_WIDTH-1:0]     o_trace_instr,
  output logic                       o_tracing_active,
  output logic                       o_wfi_stopped
);

  localparam logic [CTRL_ADDR_WIDTH-1:0] AddrStartEn    = CTRL_ADDR_WIDTH'('h00);
  localparam logic [CTRL_ADDR_WIDTH-1:0] AddrEndEn      = CTRL_ADDR_WIDTH'('h01);
  localparam logic [CTRL_ADDR_WIDTH-1:0] AddrStartAddr  = CTRL_ADDR_WIDTH'('h02);
  localparam logic [CTRL_ADDR_WIDTH-1:0] AddrEndAddr    = CTRL_ADDR_WIDTH'('h03);
  localparam logic [CTRL_ADDR_WIDTH-1:0] AddrLowerEn    = CTRL_ADDR_WIDTH'('h04);
  localparam logic [CTRL_ADDR_WIDTH-1:0] AddrUpperEn    = CTRL_ADDR_WIDTH'('h05);
  localparam logic [CTRL_ADDR_WIDTH-1:0] AddrLower      = CTRL_ADDR_WIDTH'('h06);
  localparam logic [CTRL_ADDR_WIDTH-1:0] AddrUpper      = CTRL_ADDR_WIDTH'('h07);
  localparam logic [CTRL_ADDR_WIDTH-1:0] AddrWfiStopped = CTRL_ADDR_WIDTH'('h08);
  localparam logic [CTRL_ADDR_WIDTH-1:0] AddrClkCounter = CTRL_ADDR_WIDTH'('h09);
  localparam logic [CTRL_ADDR_WIDTH-1:0] AddrLastWrTs   = CTRL_ADDR_WIDTH'('h0A);

`ifdef CMS_TRACE_CTRL_WFI_STOP_EN
  localparam logic [INSTR_WIDTH-1:0] WfiInstr = INSTR_WIDTH'(32'h1050_0073);
  typedef enum logic [1:0] {StWaitStart, StTracing, StStopped} state_e;
`else
  typedef enum logic [1:0] {StWaitStart, StTracing} state_e;
`endif

  // Configuration registers
  logic                         r_start_en, r_end_en, r_lower_en, r_upper_en;
  logic [XLEN-1:0]              r_start_addr, r_end_addr, r_lower, r_upper;
  logic [CLK_COUNTER_WIDTH-1:0] r_clk_cnt, r_last_ts;

  // FSM and trace output registers
  state_e                       r_state;
  logic                         r_tracing_active;
  logic                         r_trace_valid;
  logic [XLEN-1:0]              r_trace_pc;
  logic [INSTR_WIDTH-1:0]       r_trace_instr;
  logic [CTRL_DATA_WIDTH-1:0]   r_ctrl_rdata;

  state_e                       w_state_d;
  logic                         w_start_hit, w_end_hit, w_in_range;
  logic                         w_traced, w_fwd;
  logic [CTRL_DATA_WIDTH-1:0]   w_rdata;

  // All decisions below use the registered configuration, so a same-cycle
  // control write only takes effect for the next instruction.
  assign w_start_hit = r_start_en && (i_pc == r_start_addr);
  assign w_end_hit   = r_end_en && (i_pc == r_end_addr);
  assign w_in_range  = (!r_lower_en || (i_pc >= r_lower)) &&
                       (!r_upper_en || (i_pc <= r_upper));
  // Range only gates forwarding; triggers still act on out-of-range pcs.
  assign w_fwd       = w_traced && w_in_range;

  always_comb begin
    w_traced  = 1'b0;
    w_state_d = r_state;
    case (r_state)
      StWaitStart: begin
        if (!r_start_en) begin
          w_state_d = StTracing;
        end else if (i_instr_valid && w_start_hit) begin
          w_traced  = 1'b1;
          // Start and end on the same instruction leaves the window armed.
          w_state_d = w_end_hit ? StWaitStart : StTracing;
        end
      end
      StTracing: begin
        if (i_instr_valid) begin
          w_traced = 1'b1;
          if (w_end_hit) w_state_d = StWaitStart;
        end
      end
`ifdef CMS_TRACE_CTRL_WFI_STOP_EN
      StStopped: ;
`endif
      default: w_state_d = StWaitStart;
    endcase

`ifdef CMS_TRACE_CTRL_WFI_STOP_EN
    if (i_instr_valid && (i_instr == WfiInstr) && (r_state != StStopped)) begin
      w_state_d = StStopped;
    end
    // Software control of the stop state overrides instruction-driven moves.
    if (i_ctrl_write_enable && (i_ctrl_addr == AddrWfiStopped)) begin
      if (i_ctrl_wdata[0]) begin
        w_state_d = StStopped;
      end else if (r_state == StStopped) begin
        w_state_d = StWaitStart;
      end
    end
`endif
  end

  // Window FSM with registered status and trace outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= StWaitStart;
      r_tracing_active <= 1'b0;
      r_trace_valid    <= 1'b0;
      r_trace_pc       <= '0;
      r_trace_instr    <= '0;
    end else begin
      r_state          <= w_state_d;
      r_tracing_active <= (w_state_d == StTracing);
      r_trace_valid    <= w_fwd;
      if (w_fwd) begin
        r_trace_pc    <= i_pc;
        r_trace_instr <= i_instr;
      end
    end
  end

`ifdef CMS_TRACE_CTRL_WFI_STOP_EN
  logic r_wfi_stopped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wfi_stopped <= 1'b0;
    end else begin
      r_wfi_stopped <= (w_state_d == StStopped);
    end
  end

  assign o_wfi_stopped = r_wfi_stopped;
`else
  assign o_wfi_stopped = 1'b0;
`endif

  // Configuration register writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_en   <= 1'b0;
      r_end_en     <= 1'b0;
      r_lower_en   <= 1'b0;
      r_upper_en   <= 1'b0;
      r_start_addr <= '0;
      r_end_addr   <= '0;
      r_lower      <= '0;
      r_upper      <= '0;
    end else if (i_ctrl_write_enable) begin
      case (i_ctrl_addr)
        AddrStartEn:   r_start_en   <= i_ctrl_wdata[0];
        AddrEndEn:     r_end_en     <= i_ctrl_wdata[0];
        AddrStartAddr: r_start_addr <= XLEN'(i_ctrl_wdata);
        AddrEndAddr:   r_end_addr   <= XLEN'(i_ctrl_wdata);
        AddrLowerEn:   r_lower_en   <= i_ctrl_wdata[0];
        AddrUpperEn:   r_upper_en   <= i_ctrl_wdata[0];
        AddrLower:     r_lower      <= XLEN'(i_ctrl_wdata);
        AddrUpper:     r_upper      <= XLEN'(i_ctrl_wdata);
        default: ;
      endcase
    end
  end

  // Free-running counter; a write wins over the increment. The timestamp
  // samples the counter while the trace output register holds an item.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_cnt <= '0;
      r_last_ts <= '0;
    end else begin
      if (i_ctrl_write_enable && (i_ctrl_addr == AddrClkCounter)) begin
        r_clk_cnt <= CLK_COUNTER_WIDTH'(i_ctrl_wdata);
      end else begin
        r_clk_cnt <= r_clk_cnt + CLK_COUNTER_WIDTH'(1);
      end
      if (r_trace_valid) r_last_ts <= r_clk_cnt;
    end
  end

  // Read mux; registered so data reflects pre-edge register values
  always_comb begin
    w_rdata = '0;
    case (i_ctrl_addr)
      AddrStartEn:    w_rdata = CTRL_DATA_WIDTH'(r_start_en);
      AddrEndEn:      w_rdata = CTRL_DATA_WIDTH'(r_end_en);
      AddrStartAddr:  w_rdata = CTRL_DATA_WIDTH'(r_start_addr);
      AddrEndAddr:    w_rdata = CTRL_DATA_WIDTH'(r_end_addr);
      AddrLowerEn:    w_rdata = CTRL_DATA_WIDTH'(r_lower_en);
      AddrUpperEn:    w_rdata = CTRL_DATA_WIDTH'(r_upper_en);
      AddrLower:      w_rdata = CTRL_DATA_WIDTH'(r_lower);
      AddrUpper:      w_rdata = CTRL_DATA_WIDTH'(r_upper);
`ifdef CMS_TRACE_CTRL_WFI_STOP_EN
      AddrWfiStopped: w_rdata = CTRL_DATA_WIDTH'(r_wfi_stopped);
`endif
      AddrClkCounter: w_rdata = CTRL_DATA_WIDTH'(r_clk_cnt);
      AddrLastWrTs:   w_rdata = CTRL_DATA_WIDTH'(r_last_ts);
      default:        w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl_rdata <= '0;
    end else begin
      r_ctrl_rdata <= w_rdata;
    end
  end

  assign o_ctrl_rdata     = r_ctrl_rdata;
  assign o_trace_valid    = r_trace_valid;
  assign o_trace_pc       = r_trace_pc;
  assign o_trace_instr    = r_trace_instr;
  assign o_tracing_active = r_tracing_active;

endmodule

// File: doc/trace_window_controller.md
# trace_window_controller

Control-register front end and trace-window sequencer for the continuous monitoring system. It decodes the 8-bit control address space, holds the trigger, range and stop configuration, and runs the state machine that decides which retired instructions are forwarded to the trace filter. It also maintains the free-running clock counter and the last-write timestamp. It sits between the core's retirement port and the trace filter / AXI export path.

## Interface
Parameters:
- XLEN, 64, program counter width
- INSTR_WIDTH, 32, instruction width
- CTRL_ADDR_WIDTH, 8, control address width
- CTRL_DATA_WIDTH, 64, control data width
- CLK_COUNTER_WIDTH, 64, clock counter width

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- ctrl_addr  in  CTRL_ADDR_WIDTH  control register address (ctrl_addr_t encoding)
- ctrl_wdata  in  CTRL_DATA_WIDTH  control write data
- ctrl_write_enable  in  1  write strobe, one write per high cycle
- ctrl_rdata  out  CTRL_DATA_WIDTH  registered read data for ctrl_addr
- pc  in  XLEN  retired instruction address
- instr  in  INSTR_WIDTH  retired instruction
- instr_valid  in  1  pc/instr valid this cycle
- trace_valid  out  1  forwarded instruction valid
- trace_pc  out  XLEN  forwarded pc
- trace_instr  out  INSTR_WIDTH  forwarded instruction
- tracing_active  out  1  state == TRACING
- wfi_stopped  out  1  state == STOPPED

## Operation
- Registers: START_EN and END_EN (bit 0); START_ADDR and END_ADDR; LOWER_EN and UPPER_EN (bit 0); LOWER and UPPER; WFI_STOPPED; CLK_COUNTER; LAST_WRITE_TIMESTAMP.
- Enable registers store bit 0 only and read back zero-extended.
- Unmapped addresses: writes ignored, reads return 0.
- LAST_WRITE_TIMESTAMP is read-only; writes to it are ignored.
- FSM states:
  - WAIT_START: reset state.
    - If START_EN=0, go to TRACING on the next cycle; no instruction is traced in that cycle.
    - If START_EN=1, a valid instruction with pc==START_ADDR is traced and the state goes to TRACING.
  - TRACING: every valid instruction is traced. A valid instruction with END_EN=1 and pc==END_ADDR is traced, then the state returns to WAIT_START (re-arm).
  - STOPPED: nothing is traced.
- Start and end hit on the same instruction in WAIT_START: the instruction is traced and the state stays WAIT_START.
- Range qualifier, applied to "traced" instructions:
  - LOWER_EN requires pc >= LOWER; UPPER_EN requires pc <= UPPER. Comparisons are unsigned and inclusive.
  - An out-of-range instruction is not forwarded, but still drives trigger and state evaluation.
- WFI: in any state except STOPPED, a valid instr==32'h10500073 goes to STOPPED. The WFI itself is forwarded if it would otherwise be traced.
- Writes to WFI_STOPPED:
  - wdata[0]=1 forces STOPPED from any state.
  - wdata[0]=0 in STOPPED goes to WAIT_START.
  - Reads return {63'b0, wfi_stopped}.
- CLK_COUNTER increments every cycle and wraps from all-ones to 0. A write loads wdata, and that write has priority over the increment.
- LAST_WRITE_TIMESTAMP captures CLK_COUNTER in each cycle where trace_valid is 1 (the output register).
- Control write and instruction in the same cycle: the instruction is evaluated with the old configuration; the new value applies from the next cycle.

## Timing
- trace_valid, trace_pc and trace_instr are registered, 1 cycle after the qualifying instr_valid. This gives full throughput: one instruction per cycle.
- trace_pc and trace_instr update only when a forwarded instruction loads them; they hold otherwise.
- ctrl_rdata is registered: it reflects the ctrl_addr of the previous cycle and the register values before that cycle's edge.
- tracing_active and wfi_stopped are decoded from the state register and change on the edge of the transition.
- Reset values: all outputs 0; all configuration registers 0; CLK_COUNTER 0; state WAIT_START.
- Reset asserted mid-window aborts immediately; no trace_valid is produced after rst_n falls.

## Configuration
- CMS_TRACE_CTRL_WFI_STOP_EN defined:
  - WFI detection and WFI_STOPPED writes behave as above.
- Undefined:
  - The STOPPED state and its logic are removed.
  - WFI is traced like any other instruction.
  - WFI_STOPPED writes are ignored and reads return 0.
  - wfi_stopped is tied to 0.

## Test plan
- Start/end window: START_EN=1, START=0x1000; END_EN=1, END=0x1010; stream pcs 0xFF8..0x1018 in steps of 4 → exactly pcs 0x1000–0x1010 forwarded (5 items), each 1 cycle later; tracing_active falls after 0x1010.
- No start trigger: after reset with all configuration 0 → tracing_active=1 on cycle 1; all subsequent valid instructions are forwarded back-to-back.
- Range filter: LOWER_EN=1, LOWER=0x2000; UPPER_EN=1, UPPER=0x2008; tracing active; pcs 0x1FFC, 0x2000, 0x2008, 0x200C → only 0x2000 and 0x2008 forwarded.
- WFI stop (macro on): instr 0x10500073 at pc 0x3000 while tracing → it is forwarded; wfi_stopped=1; later instructions dropped. Write WFI_STOPPED=0 → WAIT_START. With the macro off, the same WFI is forwarded and tracing continues.
- Counter and timestamp: write CLK_COUNTER=0xFFFF_FFFF_FFFF_FFFE; read it on the next cycles → values wrap through 0. A trace item emitted when the counter is 5 → LAST_WRITE_TIMESTAMP reads 5.
- Same-cycle and reset: write START_ADDR in the same cycle as an instruction at the new address → not triggered. Assert rst_n=0 mid-window → all outputs 0 asynchronously; the state is WAIT_START after release.
